// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN (adds a 'sub' port selecting subtract/add).
package serial_sub_pkg;

    // Default operand/result width
    localparam int SERIAL_SUB_WIDTH = 8;

    // Control states: wait for a request, step through the bits, pulse completion
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Single-bit half subtractor: difference and borrow of x - y.
// Two of these plus an OR form one full-subtract bit cell.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    // Purely combinational cell
    always_comb begin
        d = x ^ y;
        b = ~x & y;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtract cell and a borrow flop
// process one bit per clock, LSB first, behind a start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN adds input 'sub'
// (sampled with start); sub=0 performs a serial add and 'borrow' reports carry.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bin_q, bin_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic               sub_q, sub_d;
`endif

    logic               hs0_d, hs0_b;
    logic               bit_d, hs1_b;
    logic               bout;
    logic               last_step;

    // Full-subtract bit cell: (a0 - b0) first, then subtract the borrow-in
    half_subtractor u_hs_ab (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .d (hs0_d),
        .b (hs0_b)
    );

    half_subtractor u_hs_bin (
        .x (hs0_d),
        .y (bin_q),
        .d (bit_d),
        .b (hs1_b)
    );

    // Borrow-out of the cell, or carry-out when configured to add
    always_comb begin
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (sub_q) begin
            bout = hs0_b | hs1_b;
        end else begin
            bout = (a_sh_q[0] & b_sh_q[0]) | (hs0_d & bin_q);
        end
`else
        bout = hs0_b | hs1_b;
`endif
    end

    assign last_step = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            sub_q    <= sub_d;
`endif
        end
    end

    // Next-state logic: start is only looked at in IDLE, so it is never queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per SHIFT cycle
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        sub_d    = sub_q;
`endif
        if (state_q == IDLE && start) begin
            a_sh_d = a;
            b_sh_d = b;
            res_d  = '0;
            bin_d  = 1'b0;
            cnt_d  = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            sub_d  = sub;
`endif
        end else if (state_q == SHIFT) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {bit_d, res_q[WIDTH-1:1]};
            bin_d  = bout;
            // Counter saturates at the last bit rather than wrapping
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (last_step) begin
                diff_d   = {bit_d, res_q[WIDTH-1:1]};
                borrow_d = bout;
            end
        end
    end

    // Outputs decoded from state; results come straight from their holding flops
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        diff   = diff_q;
        borrow = borrow_q;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor built from a chain-of-one half-subtractor cell plus a borrow flip-flop: it takes two operands with a start pulse and returns the difference and final borrow after WIDTH bit-steps. It is the inverse arithmetic direction of the team's half-adder datapath cells. It is the first sequential arithmetic block in the set: small-area, multi-cycle subtraction behind a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result, a − b mod 2^WIDTH
- borrow  output  1  final borrow; 1 when a < b unsigned

The design uses one clock. Reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state: IDLE.
- IDLE with start=1:
  - Load a and b into shift registers.
  - Clear the borrow flop and the bit counter.
  - Go to SHIFT.
- IDLE with start=0: hold.
- SHIFT, every cycle, on the LSBs a0 and b0 with borrow-in bin:
  - d = a0 ^ b0 ^ bin
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
  - Shift d into the MSB of the internal result register.
  - Shift the operand registers right.
  - Register bout.
  - Counter +1.
- When the counter reaches WIDTH−1 and that step completes:
  - Copy the result register to diff and the final bout to borrow.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start in SHIFT or DONE is ignored and not queued.
- diff and borrow change only at completion. They hold their value until the next completion or reset.
- Counter width is $clog2(WIDTH). No wrap beyond WIDTH−1.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow=0, state IDLE, all internal registers 0.
- Start sampled at edge E0:
  - busy=1 from E0.
  - Bit i is processed at edge E0+1+i.
  - diff and borrow are valid, done=1 and busy=1 after edge E0+WIDTH.
  - done=0 and busy=0 after edge E0+WIDTH+1.
- Latency: start edge to done high is WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles. A new start may be sampled at E0+WIDTH+2.
- Reset asserted mid-operation: return to IDLE immediately. All outputs clear. The partial result is discarded.
- a and b may change freely after the start edge.

## Configuration
- SERIAL_SUB_ADD_MODE_EN defined:
  - Adds port sub (input, 1), sampled with start.
  - sub=1: subtract exactly as above.
  - sub=0: serial add. d = a0 ^ b0 ^ cin, cout = (a0 & b0) | ((a0 ^ b0) & cin).
  - The borrow port then reports the final carry.
- SERIAL_SUB_ADD_MODE_EN undefined: no sub port; subtract only.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the WIDTH default constant
- Sub-module half_subtractor (inputs x, y; outputs d = x^y, b = ~x & y):
  - Instantiated twice to form the full-subtract bit cell.
  - The borrow-out is the OR of the two cell borrows.

## Test plan
- a=0x05, b=0x03, start → after 8 cycles: diff=0x02, borrow=0, done pulse 1 cycle.
- a=0x03, b=0x05 → diff=0xFE, borrow=1. a=0x00, b=0x00 → diff=0x00, borrow=0.
- a=0xFF, b=0x01, then start held high through busy → exactly one result (diff=0xFE). Next start accepted only after IDLE.
- Start a=0x80, b=0x01, assert rst_n=0 at bit step 4 → all outputs 0 immediately. A new op a=0x10, b=0x01 after reset → diff=0x0F.
- Exhaustive WIDTH=4 sweep of all a, b pairs → diff=(a−b)&0xF, borrow=(a<b). done occurs at exactly WIDTH cycles each time.
- With SERIAL_SUB_ADD_MODE_EN and sub=0: a=0xFF, b=0x01 → diff=0x00, borrow(carry)=1. a=0x12, b=0x34 → diff=0x46, borrow=0.
